pixel_pack_128: RTL and testbench

PIXEL_PACK_128 -- requirements
Module: pixel_pack_128

---
 rtl/pixel_pack_128_pkg.sv | 24 ++
 rtl/pix_packer_4to1.sv | 75 +++++++
 rtl/pixel_pack_128.sv | 158 +++++++++++++++
 tb/tb_pixel_pack_128.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_128_pkg.sv
// Shared types and constants for the 24-bit RGB to 128-bit word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pixel_pack_128_pkg;

  localparam int         PIX_PER_WORD = 4;
  localparam logic [7:0] PAD_BYTE     = 8'h00;
  localparam int         FRAME_CNT_W  = 16;
  localparam int         PIX_W        = 24;
  localparam int         LANE_W       = 32;
  localparam int         WORD_W       = PIX_PER_WORD * LANE_W;

  typedef enum logic [1:0] {
    S_SKIP   = 2'd0,
    S_ARM    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // One pixel occupies one 32-bit lane, RGB in the low 24 bits.
  function automatic logic [LANE_W-1:0] widen_pix(input logic [PIX_W-1:0] pix);
    return {PAD_BYTE, pix};
  endfunction

endpackage

// File: rtl/pix_packer_4to1.sv
// Collects four widened pixels into one 128-bit word; flush emits a zero-padded partial word.
// Latency: word is presented the cycle after its 4th pixel (or the cycle after flush_i).
// Backpressure: none; the consumer must accept every wr_en_o pulse.
//
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   clr_i           drop any partially assembled word (highest priority)
//   pix_vld_i/pix_i one pixel per asserted cycle
//   flush_i         emit the partial word, if any, zero-padded
//   wr_en_o/data_o  one-cycle write strobe; data_o holds between strobes
module pix_packer_4to1
  import pixel_pack_128_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              pix_vld_i,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic              flush_i,
  output logic              wr_en_o,
  output logic [WORD_W-1:0] data_o
);

  localparam int CNT_W = $clog2(PIX_PER_WORD);
  localparam int ACC_W = (PIX_PER_WORD - 1) * LANE_W;

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [WORD_W-1:0] r_data;
  logic              r_wr_en;

  logic              w_last;
  logic [WORD_W-1:0] w_flush_word;

  assign w_last = (r_cnt == CNT_W'(PIX_PER_WORD - 1));

  // Pixels enter at the top of the accumulator and shift down, so the first
  // pixel of a word lands in lane 0. A partial word is realigned by shifting
  // out the lanes that were never filled; the vacated top lanes read as zero.
  assign w_flush_word = {LANE_W'(0), r_acc} >> (LANE_W * (PIX_PER_WORD - 1 - int'(r_cnt)));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (clr_i) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (pix_vld_i) begin
        if (w_last) begin
          r_data  <= {widen_pix(pix_i), r_acc};
          r_wr_en <= 1'b1;
          r_cnt   <= '0;
          r_acc   <= '0;
        end else begin
          r_acc <= {widen_pix(pix_i), r_acc[ACC_W-1:LANE_W]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (flush_i && (r_cnt != '0)) begin
        r_data  <= w_flush_word;
        r_wr_en <= 1'b1;
        r_cnt   <= '0;
        r_acc   <= '0;
      end
    end
  end

  assign wr_en_o = r_wr_en;
  assign data_o  = r_data;

endmodule

// File: rtl/pixel_pack_128.sv
// Frame-aware packer: skips settling frames, then packs each line into 128-bit words.
// Latency: write strobe one cycle after the 4th pixel of a word, or one cycle after de_i falls for a partial word.
// Backpressure: none; pk_wr_en_o must be consumed every pulse.
//
// Ports:
//   clk_i, rst_n_i     pixel clock, synchronous active-low reset
//   fs_i, de_i, rgb_i  frame sync (rising edge), pixel valid, 24-bit RGB pixel
//   pk_fs_o            one-cycle pulse per accepted frame start
//   pk_wr_en_o/data_o  packed word strobe and data (data holds between strobes)
//   pk_line_end_o      pulses with the last word of a line
//   frame_cnt_o        completed frames (wrapping); err_o sticky framing error
module pixel_pack_128
  import pixel_pack_128_pkg::*;
#(
  parameter int H_CNT       = 1280,
  parameter int V_CNT       = 720,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   fs_i,
  input  logic                   de_i,
  input  logic [PIX_W-1:0]       rgb_i,
  output logic                   pk_fs_o,
  output logic                   pk_wr_en_o,
  output logic [WORD_W-1:0]      pk_data_o,
  output logic                   pk_line_end_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   err_o
);

  localparam int PIX_CNT_W  = $clog2(H_CNT + 1);
  localparam int LINE_CNT_W = $clog2(V_CNT + 1);
  localparam int LANE_SEL_W = $clog2(PIX_PER_WORD);

  localparam logic [PIX_CNT_W-1:0]  H_MAX     = PIX_CNT_W'(H_CNT);
  localparam logic [PIX_CNT_W-1:0]  H_LAST    = PIX_CNT_W'(H_CNT - 1);
  localparam logic [LINE_CNT_W-1:0] V_MAX     = LINE_CNT_W'(V_CNT);
  localparam logic [LINE_CNT_W-1:0] V_LAST    = LINE_CNT_W'(V_CNT - 1);
  localparam logic [7:0]            SKIP_LAST = 8'(SKIP_FRAMES - 1);
  localparam state_t                RST_STATE = (SKIP_FRAMES == 0) ? S_ARM : S_SKIP;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_fs_d;
  logic                     r_de_d;
  logic [7:0]               r_skip_cnt;
  logic [PIX_CNT_W-1:0]     r_pix_cnt;
  logic [LINE_CNT_W-1:0]    r_line_cnt;
  logic [FRAME_CNT_W-1:0]   r_frame_cnt;
  logic                     r_err;
  logic                     r_pk_fs;
  logic                     r_line_end;

  logic w_fs_rise;
  logic w_pk_fs_nxt;
  logic w_take;
  logic w_frame_done;
  logic w_line_full;
  logic w_pix_acc;
  logic w_pix_drop;
  logic w_eol;
  logic w_flush;
  logic w_line_last;
  logic w_abort;
  logic w_len_err;
  logic w_frame_end;

  assign w_fs_rise = fs_i & ~r_fs_d;

  // Line traffic is only looked at in S_ACTIVE, and never on a frame-sync
  // cycle: the sync wins and any pixel presented with it is dropped.
  assign w_take       = (r_state == S_ACTIVE) & ~w_fs_rise;
  assign w_frame_done = (r_line_cnt == V_MAX);
  assign w_line_full  = (r_pix_cnt == H_MAX);
  assign w_pix_acc    = w_take & de_i & ~w_frame_done & ~w_line_full;
  assign w_pix_drop   = w_take & de_i & (w_frame_done | w_line_full);
  assign w_eol        = w_take & r_de_d & ~de_i;
  assign w_flush      = w_eol & (r_pix_cnt[LANE_SEL_W-1:0] != '0);
  assign w_line_last  = w_pix_acc & (r_pix_cnt == H_LAST);
  assign w_len_err    = w_eol & (r_pix_cnt != H_MAX);
  assign w_frame_end  = w_eol & ~w_frame_done & (r_line_cnt == V_LAST);
  assign w_abort      = (r_state == S_ACTIVE) & w_fs_rise & (r_line_cnt != '0) & ~w_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    w_pk_fs_nxt = 1'b0;
    unique case (r_state)
      S_SKIP: begin
        if (w_fs_rise && (r_skip_cnt == SKIP_LAST)) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (w_fs_rise) begin
          w_state_nxt = S_ACTIVE;
          w_pk_fs_nxt = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Every sync restarts the frame, clean or not.
        w_pk_fs_nxt = w_fs_rise;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= RST_STATE;
      r_fs_d      <= 1'b0;
      r_de_d      <= 1'b0;
      r_skip_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
      r_pk_fs     <= 1'b0;
      r_line_end  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fs_d     <= fs_i;
      // Only de_i seen during active line traffic can produce a line end, so a
      // de_i already high when the frame starts does not count as a line.
      r_de_d     <= w_take & de_i;
      r_pk_fs    <= w_pk_fs_nxt;
      r_line_end <= w_line_last | w_flush;

      if ((r_state == S_SKIP) && w_fs_rise) r_skip_cnt <= r_skip_cnt + 8'd1;

      if (w_fs_rise || w_eol) r_pix_cnt <= '0;
      else if (w_pix_acc)     r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);

      // Saturates at V_CNT so surplus lines cannot disturb the next sync check.
      if (w_fs_rise)                      r_line_cnt <= '0;
      else if (w_eol && !w_frame_done)    r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);

      if (w_frame_end) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);

      if (w_abort || w_pix_drop || w_len_err) r_err <= 1'b1;
    end
  end

  pix_packer_4to1 u_packer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (w_fs_rise),
    .pix_vld_i (w_pix_acc),
    .pix_i     (rgb_i),
    .flush_i   (w_flush),
    .wr_en_o   (pk_wr_en_o),
    .data_o    (pk_data_o)
  );

  assign pk_fs_o       = r_pk_fs;
  assign pk_line_end_o = r_line_end;
  assign frame_cnt_o   = r_frame_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_pixel_pack_128.sv
// Bench for pixel_pack_128: randomized lines checked against a line/frame-level model.
// Latency: model predicts the exact cycle of every write strobe.
// Backpressure: n/a.
module tb_pixel_pack_128;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SK = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fs;
  logic         de;
  logic [23:0]  rgb;
  logic         pk_fs;
  logic         pk_wr_en;
  logic [127:0] pk_data;
  logic         pk_line_end;
  logic [15:0]  frame_cnt;
  logic         err;

  pixel_pack_128 #(.H_CNT(H), .V_CNT(V), .SKIP_FRAMES(SK)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .fs_i          (fs),
    .de_i          (de),
    .rgb_i         (rgb),
    .pk_fs_o       (pk_fs),
    .pk_wr_en_o    (pk_wr_en),
    .pk_data_o     (pk_data),
    .pk_line_end_o (pk_line_end),
    .frame_cnt_o   (frame_cnt),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] dat;
    logic         le;
    int           cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int cyc        = 0;
  int n_fs_obs   = 0;
  int n_stray_le = 0;
  int n_tests    = 0;
  int n_fail     = 0;

  // Reference model state (frame/line level).
  int          m_skip;
  int          m_lines;
  int          m_fs_exp = 0;
  bit          m_act;
  bit          m_err;
  logic [15:0] m_frames;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pk_wr_en === 1'b1) obs_q.push_back('{dat: pk_data, le: pk_line_end, cyc: cyc});
    if (pk_line_end === 1'b1 && pk_wr_en !== 1'b1) n_stray_le++;
    if (pk_fs === 1'b1) n_fs_obs++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_skip   = SK;
    m_lines  = 0;
    m_act    = 1'b0;
    m_err    = 1'b0;
    m_frames = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pk_fs"}, pk_fs, 0);
    chk({tag, " wr_en"}, pk_wr_en, 0);
    chk({tag, " data"}, pk_data, 0);
    chk({tag, " line_end"}, pk_line_end, 0);
    chk({tag, " frame_cnt"}, frame_cnt, 0);
    chk({tag, " err"}, err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fs = 1'b0; de = 1'b0;
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Frame sync pulse; optionally with de_i high on the same cycle.
  task automatic send_fs(input bit with_de);
    fs = 1'b1; de = with_de; rgb = 24'($urandom);
    tick();
    fs = 1'b0; de = 1'b0;
    tick();
    if (m_skip > 0) m_skip--;
    else if (!m_act) begin
      m_act = 1'b1;
      m_fs_exp++;
    end else begin
      if (m_lines != 0 && m_lines != V) m_err = 1'b1;
      m_lines = 0;
      m_fs_exp++;
    end
  endtask

  // One line of n pixels followed by gap cycles of de_i low.
  task automatic send_line(input int n, input bit seq, input logic [23:0] base, input int gap);
    logic [127:0] word;
    logic [23:0]  px;
    int           lane;
    int           k;
    bit           open;
    word = '0; lane = 0; k = 0;
    open = m_act && (m_lines < V);
    for (int i = 0; i < n; i++) begin
      px  = seq ? base + 24'(i) : 24'($urandom);
      rgb = px; de = 1'b1;
      tick();
      if (open && k < H) begin
        word[32*lane +: 32] = {8'h00, px};
        lane++; k++;
        if (lane == 4) begin
          exp_q.push_back('{dat: word, le: (k == H), cyc: cyc});
          word = '0; lane = 0;
        end
      end else if (m_act) m_err = 1'b1;
    end
    de = 1'b0; rgb = 24'($urandom);
    tick();
    if (open) begin
      if (lane != 0) exp_q.push_back('{dat: word, le: 1'b1, cyc: cyc});
      if (k != H) m_err = 1'b1;
      m_lines++;
      if (m_lines == V) m_frames++;
    end
    repeat (gap - 1) tick();
  endtask

  task automatic check_writes(input string tag);
    repeat (3) tick();
    chk({tag, " write count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s word%0d data", tag, i), obs_q[i].dat, exp_q[i].dat);
      chk($sformatf("%s word%0d line_end", tag, i), obs_q[i].le, exp_q[i].le);
      chk($sformatf("%s word%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, " err"}, err, m_err);
    chk({tag, " frame_cnt"}, frame_cnt, m_frames);
    chk({tag, " pk_fs pulses"}, n_fs_obs, m_fs_exp);
    chk({tag, " stray line_end"}, n_stray_le, 0);
  endtask

  initial begin
    logic [127:0] w;
    rst_n = 1'b0; fs = 1'b0; de = 1'b0; rgb = '0;
    tick();
    do_reset();

    // Three frames: two settling frames ignored, third packed from 1..32.
    for (int f = 0; f < 3; f++) begin
      send_fs(1'b0);
      tick();
      for (int l = 0; l < V; l++) send_line(H, (f == 2), 24'(l * H + 1), 2);
    end
    repeat (3) tick();
    w = (obs_q.size() > 0) ? obs_q[0].dat : '1;
    chk("first word", w, 128'h00000004_00000003_00000002_00000001);
    check_writes("skip frames");
    check_status("skip frames");

    // Clean random frame; its sync arrives together with a pixel.
    send_fs(1'b1);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, '0, $urandom_range(1, 3));
    check_writes("clean frame");
    check_status("clean frame");

    // Sync after two lines and a partial word, then a full frame.
    send_fs(1'b0);
    for (int l = 0; l < 2; l++) send_line(H, 1'b0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      rgb = 24'($urandom); de = 1'b1;
      tick();
    end
    send_fs(1'b1);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, '0, $urandom_range(1, 3));
    check_writes("abort");
    check_status("abort");

    // Short line: partial word flushed with zero padding.
    do_reset();
    repeat (3) send_fs(1'b0);
    send_line(6, 1'b0, '0, 2);
    for (int l = 1; l < V; l++) send_line(H, 1'b0, '0, 2);
    repeat (3) tick();
    w = (obs_q.size() > 1) ? obs_q[1].dat : '1;
    chk("short line upper half", w[127:64], 64'h0);
    check_writes("short line");
    check_status("short line");

    // Overlong line, then a surplus line after the frame completes.
    do_reset();
    repeat (3) send_fs(1'b0);
    send_line(H + 2, 1'b0, '0, 2);
    for (int l = 1; l < V; l++) send_line(H, 1'b0, '0, 1);
    send_line(H, 1'b0, '0, 2);
    check_writes("overrun");
    check_status("overrun");

    // Reset after two pixels of a word: nothing emitted, skipping restarts.
    do_reset();
    repeat (3) send_fs(1'b0);
    for (int i = 0; i < 2; i++) begin
      rgb = 24'($urandom); de = 1'b1;
      tick();
    end
    rst_n = 1'b0; de = 1'b0;
    tick();
    chk_idle("mid-word reset");
    rst_n = 1'b1;
    model_reset();
    check_writes("mid-word reset");
    send_fs(1'b0);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, '0, 1);
    check_writes("resettle frame");
    send_fs(1'b0);
    send_fs(1'b0);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, '0, 2);
    check_writes("post-reset frame");
    check_status("post-reset frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
